// File: rtl/cv32e40p_div_pkg.sv
// rtl/cv32e40p_div_pkg.sv - shared types and default widths for the divider front end
package cv32e40p_div_pkg;

   localparam int DIV_WIDTH     = 32;
   localparam int DIV_LOG_WIDTH = 6;

   typedef enum logic [1:0] {
      DIV_UDIV = 2'd0,
      DIV_DIV  = 2'd1,
      DIV_UREM = 2'd2,
      DIV_REM  = 2'd3
   } div_opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RESP  = 3'd3,
      ST_DRAIN = 3'd4
   } div_state_e;

endpackage

// File: rtl/cv32e40p_div_shift_calc.sv
// rtl/cv32e40p_div_shift_calc.sv - normalising shift for the divisor (leading zeros or redundant sign bits)
module cv32e40p_div_shift_calc
   import cv32e40p_div_pkg::*;
#(
   parameter int WIDTH     = DIV_WIDTH,
   parameter int LOG_WIDTH = DIV_LOG_WIDTH
) (
   input  logic [WIDTH-1:0]     op_b,
   input  logic                 signed_op,
   output logic [LOG_WIDTH-1:0] shift,
   output logic                 is_zero,
   output logic [WIDTH-1:0]     op_b_shifted
);

   logic [WIDTH-1:0]     scan;
   logic [LOG_WIDTH-1:0] count;
   logic                 found;

   // Signed: fold sign copies to zeros and drop the sign bit, so the zero run equals the redundant sign bits.
   always_comb begin
      scan  = signed_op ? {op_b[WIDTH-2:0] ^ {(WIDTH-1){op_b[WIDTH-1]}}, 1'b1} : op_b;
      count = '0;
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!found) begin
            if (scan[i]) found = 1'b1;
            else         count = count + LOG_WIDTH'(1);
         end
      end
   end

   assign is_zero      = (op_b == '0);
   assign shift        = (count == LOG_WIDTH'(WIDTH)) ? LOG_WIDTH'(WIDTH - 1) : count;
   assign op_b_shifted = op_b << shift;

endmodule

// File: rtl/cv32e40p_reg_parity.sv
// rtl/cv32e40p_reg_parity.sv - data register with an even-parity bit and a live error flag
module cv32e40p_reg_parity #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  err
);

   logic [DATA_WIDTH-1:0] data_q;
   logic                  parity_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q   <= '0;
         parity_q <= 1'b0;
      end else if (we) begin
         data_q   <= wdata;
         parity_q <= ^wdata;
      end
   end

   assign rdata = data_q;
   assign err   = (^data_q) ^ parity_q;

endmodule

// File: rtl/cv32e40p_div_frontend.sv
// rtl/cv32e40p_div_frontend.sv - issue/retire controller around the serial divider core
module cv32e40p_div_frontend
   import cv32e40p_div_pkg::*;
#(
   parameter int WIDTH     = DIV_WIDTH,
   parameter int LOG_WIDTH = DIV_LOG_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [WIDTH-1:0]     op_a_i,
   input  logic [WIDTH-1:0]     op_b_i,
   input  logic [1:0]           opcode_i,
   input  logic                 flush_i,
   output logic                 resp_valid_o,
   input  logic                 resp_ready_i,
   output logic [WIDTH-1:0]     resp_result_o,
   output logic                 busy_o,
   output logic [WIDTH-1:0]     div_op_a_o,
   output logic [WIDTH-1:0]     div_op_b_o,
   output logic [LOG_WIDTH-1:0] div_op_b_shift_o,
   output logic                 div_op_b_is_zero_o,
   output logic                 div_op_b_sign_o,
   output logic [1:0]           div_opcode_o,
   output logic                 div_in_vld_o,
   output logic                 div_out_rdy_o,
   input  logic                 div_out_vld_i,
   input  logic [WIDTH-1:0]     div_res_i,
   input  logic [4:0]           div_mem_err_i,
   output logic [5:0]           mem_err_o,
   output logic                 err_sticky_o
);

   div_state_e       state_q, state_d;
   logic [WIDTH-1:0] op_a_q, op_b_q;
   logic [1:0]       opcode_q;
   logic             accept, capture, res_err, err_q;

   assign req_ready_o = (state_q == ST_IDLE) || ((state_q == ST_RESP) && resp_ready_i);
   assign accept      = req_valid_i && req_ready_o;
   assign capture     = (state_q == ST_WAIT) && div_out_vld_i && !flush_i;

   // A flush coinciding with completion still handshakes the core, so it can go straight to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = ST_ISSUE;
         ST_ISSUE: state_d = flush_i ? ST_DRAIN : ST_WAIT;
         ST_WAIT: begin
            if (flush_i)            state_d = div_out_vld_i ? ST_IDLE : ST_DRAIN;
            else if (div_out_vld_i) state_d = ST_RESP;
         end
         ST_RESP: begin
            if (accept)                       state_d = ST_ISSUE;
            else if (resp_ready_i || flush_i) state_d = ST_IDLE;
         end
         ST_DRAIN: if (div_out_vld_i) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         op_a_q   <= '0;
         op_b_q   <= '0;
         opcode_q <= 2'd0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_a_q   <= op_a_i;
            op_b_q   <= op_b_i;
            opcode_q <= opcode_i;
         end
         if (|mem_err_o) err_q <= 1'b1;
      end
   end

   cv32e40p_div_shift_calc #(
      .WIDTH     (WIDTH),
      .LOG_WIDTH (LOG_WIDTH)
   ) u_shift_calc (
      .op_b         (op_b_q),
      .signed_op    (opcode_q[0]),
      .shift        (div_op_b_shift_o),
      .is_zero      (div_op_b_is_zero_o),
      .op_b_shifted (div_op_b_o)
   );

   cv32e40p_reg_parity #(
      .DATA_WIDTH (WIDTH)
   ) u_result_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (capture),
      .wdata (div_res_i),
      .rdata (resp_result_o),
      .err   (res_err)
   );

   assign div_op_a_o      = op_a_q;
   assign div_op_b_sign_o = op_b_q[WIDTH-1] & opcode_q[0];
   assign div_opcode_o    = opcode_q;
   assign div_in_vld_o    = (state_q == ST_ISSUE);
   assign div_out_rdy_o   = ((state_q == ST_WAIT) || (state_q == ST_DRAIN)) && div_out_vld_i;
   assign resp_valid_o    = (state_q == ST_RESP);
   assign busy_o          = (state_q != ST_IDLE);
   assign mem_err_o       = {res_err, div_mem_err_i};
   assign err_sticky_o    = err_q;

endmodule
